// File: rtl/traffic_driver.sv
// traffic_driver: replays a loaded packet memory into the network with a progress watchdog and per-sink back-pressure.
module traffic_driver #(
  parameter int DW        = 32,
  parameter int DEPTH     = 10000,
  parameter int NCH       = 2,
  parameter int WIN       = 10000,
  parameter int DRAIN_CYC = 10000,
  parameter int BP_PERIOD = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_en,
  input  logic [AW:0]       num_pkt,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  output logic [DW-1:0]     data_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [NCH-1:0]    sink_valid_i,
  output logic [NCH-1:0]    sink_ready_o,
  input  logic              bp_en,
  output logic [31:0]       sent_cnt,
  output logic [32*NCH-1:0] recv_cnt,
  output logic              busy,
  output logic              done,
  output logic              deadlock
);
  typedef enum logic [2:0] {IDLE, SEND, DRAIN, DONE, DLOCK} state_t;
  localparam logic [AW:0] DM = (AW+1)'(DEPTH);
  state_t state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr;
  logic [AW:0] n;
  logic [31:0] win, snap, drain;
  logic go, hs, last, wend;
  always_comb begin
    go = (state == IDLE || state == DONE) && start && num_pkt != '0;
    hs = valid_o && ready_i;
    last = {1'b0, addr} == n - 1'b1;
    wend = win == 32'(WIN - 1);
    data_o = mem[addr];
  end
  always_ff @(posedge clk)
    if (ld_en && state != SEND) mem[ld_addr] <= ld_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid_o <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      deadlock <= 1'b0;
      sent_cnt <= '0;
      addr <= '0;
      n <= '0;
      win <= '0;
      snap <= '0;
      drain <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (go) begin
          state <= SEND;
          valid_o <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          addr <= '0;
          sent_cnt <= '0;
          win <= '0;
          n <= num_pkt > DM ? DM : num_pkt;
        end
        SEND: begin
          win <= wend ? '0 : win + 32'd1;
          if (win == '0) snap <= sent_cnt;
          if (hs) begin
            sent_cnt <= sent_cnt + 32'd1;
            addr <= last ? '0 : addr + 1'b1;
          end
          // a handshake on the expiry cycle counts as progress
          if (hs && last && !loop_en) begin
            state <= DRAIN;
            valid_o <= 1'b0;
            drain <= '0;
          end else if (!hs && wend && sent_cnt == snap) begin
            state <= DLOCK;
            valid_o <= 1'b0;
            busy <= 1'b0;
            deadlock <= 1'b1;
          end
        end
        DRAIN: if (drain == 32'(DRAIN_CYC - 1)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else drain <= drain + 32'd1;
        default: ;
      endcase
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [15:0] PM = 16'(BP_PERIOD + 4*i - 1);
    logic [15:0] c;
    logic [31:0] r;
    always_ff @(posedge clk)
      c <= rst || c == PM ? '0 : c + 16'd1;
    assign sink_ready_o[i] = !rst && (!bp_en || c != PM);
    always_ff @(posedge clk)
      if (rst || go) r <= '0;
      else if (sink_valid_i[i] && sink_ready_o[i] && r != '1) r <= r + 32'd1;
    assign recv_cnt[32*i +: 32] = r;
  end
endmodule
